// File: rtl/adc_capture.sv
`default_nettype none
// ============================================================================
// Module      : adc_capture
// Description : Captures parallel ADC samples, one per ADC_CLK falling edge,
//               into an internal DEPTH x DATA_WIDTH buffer. A run can first
//               wait for a rising crossing of a programmable threshold. After
//               the run the host reads the buffer back by address.
//
// Ports
//   clk        : system clock (also drives the ADC_CLK divider)
//   rst_n      : asynchronous active-low reset
//   ADC_CLK    : divider output, already a clk-domain register
//   adc_data   : ADC parallel sample, valid around the ADC_CLK falling edge
//   start      : one-cycle pulse, arms a capture (ignored while busy)
//   abort      : one-cycle pulse, returns to IDLE (wins over start)
//   trig_en    : 1 = wait for threshold crossing, 0 = capture immediately
//   trig_level : unsigned trigger threshold
//   cap_len    : number of samples to capture minus one
//   rd_addr    : readout address
//   rd_data    : registered readout data, 1-cycle latency
//   busy       : high while waiting for trigger or capturing
//   done       : high once a run has completed
//
// Revision    : 1.0 - initial release
// ============================================================================
module adc_capture #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ADC_CLK,
    input  logic [DATA_WIDTH-1:0] adc_data,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  trig_en,
    input  logic [DATA_WIDTH-1:0] trig_level,
    input  logic [ADDR_WIDTH-1:0] cap_len,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  done
);

    localparam int c_DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_TRIG = 2'd1,
        S_CAPTURE   = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic                    r_adc_clk_d;
    logic [DATA_WIDTH-1:0]   r_smp;
    logic                    r_smp_vld;
    logic [DATA_WIDTH-1:0]   r_prev_smp;
    logic                    r_primed;       // set once the first sample after arming is seen
    logic [ADDR_WIDTH-1:0]   r_wr_addr;
    logic [ADDR_WIDTH-1:0]   r_cap_len;
    logic [DATA_WIDTH-1:0]   r_trig_level;
    logic [DATA_WIDTH-1:0]   r_rd_data;

    logic [DATA_WIDTH-1:0]   r_mem [0:c_DEPTH-1];

    logic                    w_fall;
    logic                    w_arm;
    logic                    w_trig;
    logic                    w_we;
    logic [ADDR_WIDTH-1:0]   w_waddr;
    logic [ADDR_WIDTH-1:0]   w_wr_addr_nxt;
    logic                    w_primed_nxt;

    // ------------------------------------------------------------------
    // Falling-edge detect and sample latch
    // ------------------------------------------------------------------
    assign w_fall = r_adc_clk_d & ~ADC_CLK;

    // A fall in the arming cycle is latched but not flagged valid, so it can
    // never be taken as part of the run that is just starting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_adc_clk_d <= 1'b0;
            r_smp       <= '0;
            r_smp_vld   <= 1'b0;
        end else begin
            r_adc_clk_d <= ADC_CLK;
            r_smp_vld   <= w_fall & ~w_arm;
            if (w_fall) begin
                r_smp <= adc_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state, write control and run bookkeeping
    // ------------------------------------------------------------------
    assign w_trig = r_primed && (r_prev_smp < r_trig_level) && (r_smp >= r_trig_level);

    always_comb begin
        w_state_nxt   = r_state;
        w_arm         = 1'b0;
        w_we          = 1'b0;
        w_waddr       = r_wr_addr;
        w_wr_addr_nxt = r_wr_addr;
        w_primed_nxt  = r_primed;

        if (abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        w_arm         = 1'b1;
                        w_wr_addr_nxt = '0;
                        w_primed_nxt  = 1'b0;
                        // trig_en is only needed for this one decision, so
                        // the value at start is the effective latched copy.
                        w_state_nxt   = trig_en ? S_WAIT_TRIG : S_CAPTURE;
                    end
                end
                S_WAIT_TRIG: begin
                    if (r_smp_vld) begin
                        w_primed_nxt = 1'b1;
                        if (w_trig) begin
                            w_we          = 1'b1;
                            w_waddr       = '0;
                            w_wr_addr_nxt = ADDR_WIDTH'(1);
                            w_state_nxt   = (r_cap_len == '0) ? S_DONE : S_CAPTURE;
                        end
                    end
                end
                S_CAPTURE: begin
                    if (r_smp_vld) begin
                        w_we = 1'b1;
                        if (r_wr_addr == r_cap_len) begin
                            w_state_nxt = S_DONE;
                        end else begin
                            w_wr_addr_nxt = r_wr_addr + 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_addr    <= '0;
            r_primed     <= 1'b0;
            r_prev_smp   <= '0;
            r_cap_len    <= '0;
            r_trig_level <= '0;
        end else begin
            r_wr_addr <= w_wr_addr_nxt;
            r_primed  <= w_primed_nxt;
            if (r_smp_vld) begin
                r_prev_smp <= r_smp;
            end
            if (w_arm) begin
                r_cap_len    <= cap_len;
                r_trig_level <= trig_level;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sample buffer: simple dual-port RAM, read-before-write on collision
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= r_smp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_data;
    assign busy    = (r_state == S_WAIT_TRIG) || (r_state == S_CAPTURE);
    assign done    = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_adc_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_capture
// Description : Directed self-checking bench for adc_capture. ADC_CLK is
//               modelled as a divide-by-4 clock (2 cycles high, 2 low) driven
//               from the stimulus sequence; each period presents one sample.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_capture;

    localparam int DW = 8;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ADC_CLK;
    logic [DW-1:0] adc_data;
    logic          start;
    logic          abort;
    logic          trig_en;
    logic [DW-1:0] trig_level;
    logic [AW-1:0] cap_len;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    adc_capture #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ADC_CLK    (ADC_CLK),
        .adc_data   (adc_data),
        .start      (start),
        .abort      (abort),
        .trig_en    (trig_en),
        .trig_level (trig_level),
        .cap_len    (cap_len),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .busy       (busy),
        .done       (done)
    );

    // advance n rising edges, then settle 1 time unit past the edge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // one ADC_CLK period: 2 cycles high with data, then fall and 2 cycles low
    task automatic adc_sample(input logic [DW-1:0] d);
        ADC_CLK  = 1'b1;
        adc_data = d;
        step(2);
        ADC_CLK  = 1'b0;
        step(2);
    endtask

    task automatic read_chk(input string tag, input int a, input logic [DW-1:0] exp);
        rd_addr = AW'(a);
        step(1);
        check(tag, {24'd0, rd_data}, {24'd0, exp});
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        ADC_CLK    = 1'b0;
        adc_data   = '0;
        start      = 1'b0;
        abort      = 1'b0;
        trig_en    = 1'b0;
        trig_level = '0;
        cap_len    = '0;
        rd_addr    = '0;

        // ---------------- reset state ----------------
        step(2);
        check("rst_busy",    {31'd0, busy}, 32'd0);
        check("rst_done",    {31'd0, done}, 32'd0);
        check("rst_rd_data", {24'd0, rd_data}, 32'd0);
        rst_n = 1'b1;
        step(2);

        // ---------------- 1: immediate capture of 16 counting samples ----------------
        cap_len = AW'(15);
        trig_en = 1'b0;
        pulse_start();
        check("t1_busy_after_start", {31'd0, busy}, 32'd1);
        check("t1_done_after_start", {31'd0, done}, 32'd0);
        for (int i = 0; i < 15; i++) adc_sample(DW'(i));
        ADC_CLK  = 1'b1;
        adc_data = 8'd15;
        step(2);
        ADC_CLK  = 1'b0;
        step(1);
        check("t1_done_n1", {31'd0, done}, 32'd0);
        check("t1_busy_n1", {31'd0, busy}, 32'd1);
        step(1);
        check("t1_done_n2", {31'd0, done}, 32'd1);
        check("t1_busy_n2", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 16; i++) read_chk("t1_rd", i, DW'(i));

        // ---------------- 2: rising trigger at 0x80 on a ramp ----------------
        trig_en    = 1'b1;
        trig_level = 8'h80;
        cap_len    = AW'(3);
        pulse_start();
        // changes after start must not affect the run
        trig_en    = 1'b0;
        trig_level = 8'h00;
        cap_len    = AW'(0);
        adc_sample(8'h70);
        adc_sample(8'h74);
        adc_sample(8'h78);
        adc_sample(8'h7C);
        check("t2_wait_busy", {31'd0, busy}, 32'd1);
        check("t2_wait_done", {31'd0, done}, 32'd0);
        adc_sample(8'h80);
        adc_sample(8'h84);
        adc_sample(8'h88);
        adc_sample(8'h8C);
        check("t2_done", {31'd0, done}, 32'd1);
        read_chk("t2_rd0", 0, 8'h80);
        read_chk("t2_rd1", 1, 8'h84);
        read_chk("t2_rd2", 2, 8'h88);
        read_chk("t2_rd3", 3, 8'h8C);

        // ---------------- 3: first sample already above level, no trigger ----------------
        trig_en    = 1'b1;
        trig_level = 8'h80;
        cap_len    = AW'(3);
        pulse_start();
        for (int i = 0; i < 6; i++) adc_sample(8'h90);
        check("t3_busy_held", {31'd0, busy}, 32'd1);
        check("t3_not_done",  {31'd0, done}, 32'd0);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        check("t3_abort_busy", {31'd0, busy}, 32'd0);
        check("t3_abort_done", {31'd0, done}, 32'd0);
        read_chk("t3_rd0_kept", 0, 8'h80);

        // ---------------- 4: full-depth capture ----------------
        trig_en = 1'b0;
        cap_len = AW'(1023);
        pulse_start();
        for (int i = 0; i < 1024; i++) adc_sample(DW'(i * 7 + 3));
        check("t4_done", {31'd0, done}, 32'd1);
        check("t4_busy", {31'd0, busy}, 32'd0);
        read_chk("t4_rd0",    0,    8'h03);
        read_chk("t4_rd1",    1,    8'h0A);
        read_chk("t4_rd100",  100,  8'hBF);
        read_chk("t4_rd1023", 1023, 8'hFC);

        // ---------------- 5: abort+start together mid-capture, then restart ----------------
        cap_len = AW'(7);
        pulse_start();
        adc_sample(8'h40);
        adc_sample(8'h41);
        adc_sample(8'h42);
        abort = 1'b1;
        start = 1'b1;
        step(1);
        abort = 1'b0;
        start = 1'b0;
        check("t5_abort_busy", {31'd0, busy}, 32'd0);
        check("t5_abort_done", {31'd0, done}, 32'd0);
        step(3);
        check("t5_idle_busy", {31'd0, busy}, 32'd0);
        // a fall coinciding with start must not be captured
        ADC_CLK = 1'b1;
        step(2);
        start    = 1'b1;
        ADC_CLK  = 1'b0;
        adc_data = 8'hEE;
        step(1);
        start = 1'b0;
        check("t5_restart_busy", {31'd0, busy}, 32'd1);
        step(1);
        for (int i = 0; i < 8; i++) adc_sample(DW'(8'h50 + i));
        check("t5_done", {31'd0, done}, 32'd1);
        read_chk("t5_rd0", 0, 8'h50);
        read_chk("t5_rd7", 7, 8'h57);

        // ---------------- 6: asynchronous reset mid-capture ----------------
        cap_len = AW'(15);
        pulse_start();
        adc_sample(8'h60);
        adc_sample(8'h61);
        read_chk("t6_rd15", 15, 8'h6C);
        check("t6_busy_pre", {31'd0, busy}, 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_async_busy",    {31'd0, busy}, 32'd0);
        check("t6_async_done",    {31'd0, done}, 32'd0);
        check("t6_async_rd_data", {24'd0, rd_data}, 32'd0);
        step(1);
        rst_n = 1'b1;
        step(2);
        check("t6_post_busy", {31'd0, busy}, 32'd0);
        check("t6_post_done", {31'd0, done}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
